// File: rtl/garnet_ddr_arb_pkg.sv
// garnet_ddr_arb_pkg
//   Shared widths, field offsets and the ID-prefix helper for the two-master
//   garnet_ddr AXI4 arbiter. Master-side IDs are MID_W bits wide. The slave
//   side carries one extra ID bit (bit 5) that holds the master index.
//   Payload layouts, MSB first:
//     AW/AR : {addr64, burst2, cache4, id, len8, lock1, prot3, qos4, region4, size3}
//     W     : {data512, strb64, last1}
//     B     : {id, resp2}
//     R     : {data512, id, resp2, last1}
package garnet_ddr_arb_pkg;

    localparam int MID_W = 5;
    localparam int SID_W = 6;

    // Address-channel layout (AW and AR share it)
    localparam int AX_W       = 98;
    localparam int AW_W       = AX_W;
    localparam int AR_W       = AX_W;
    localparam int SIZE_LSB   = 0;
    localparam int REGION_LSB = 3;
    localparam int QOS_LSB    = 7;
    localparam int PROT_LSB   = 11;
    localparam int LOCK_LSB   = 14;
    localparam int LEN_LSB    = 15;
    localparam int ID_LSB     = 23;
    localparam int CACHE_LSB  = 28;   // master side; one higher on the slave side
    localparam int BURST_LSB  = 32;
    localparam int ADDR_LSB   = 34;
    localparam int SAX_W      = AX_W + 1;
    localparam int SAW_W      = SAX_W;
    localparam int SAR_W      = SAX_W;

    // W layout (identical on both sides)
    localparam int W_W        = 577;
    localparam int W_LAST     = 0;
    localparam int W_STRB_LSB = 1;
    localparam int W_DATA_LSB = 65;

    // B layout
    localparam int B_W        = MID_W + 2;
    localparam int SB_W       = SID_W + 2;
    localparam int B_RESP_LSB = 0;
    localparam int B_ID_LSB   = 2;

    // R layout
    localparam int R_W        = 520;
    localparam int SR_W       = R_W + 1;
    localparam int R_LAST     = 0;
    localparam int R_RESP_LSB = 1;
    localparam int R_ID_LSB   = 3;

    // Insert the master index directly above the 5-bit master ID so that the
    // slave-side ID becomes {idx, id5}; every field above it shifts up by one.
    function automatic logic [SAX_W-1:0] prefix_id(input logic [AX_W-1:0] ax,
                                                   input logic             idx);
        return {ax[AX_W-1:ID_LSB+MID_W], idx, ax[ID_LSB+MID_W-1:0]};
    endfunction

endpackage

// File: rtl/garnet_ddr_arb_if.sv
// garnet_ddr_arb_if
//   All handshake and payload signals between the two AXI4 masters, the
//   arbiter and the garnet_ddr slave port.
//   m_* : master side, two masters packed per signal (bit/slice i = master i);
//         B and R payloads are shared, with per-master valid.
//   s_* : slave side, single port with 6-bit IDs.
//   Modports: arb (the arbiter), master (the upstream masters), slave (DDR).
interface garnet_ddr_arb_if;
    import garnet_ddr_arb_pkg::*;

    logic [1:0]         m_awvalid;
    logic [1:0]         m_awready;
    logic [2*AW_W-1:0]  m_aw;
    logic [1:0]         m_wvalid;
    logic [1:0]         m_wready;
    logic [2*W_W-1:0]   m_w;
    logic [1:0]         m_bvalid;
    logic [1:0]         m_bready;
    logic [B_W-1:0]     m_b;
    logic [1:0]         m_arvalid;
    logic [1:0]         m_arready;
    logic [2*AR_W-1:0]  m_ar;
    logic [1:0]         m_rvalid;
    logic [1:0]         m_rready;
    logic [R_W-1:0]     m_r;

    logic               s_awvalid;
    logic               s_awready;
    logic [SAW_W-1:0]   s_aw;
    logic               s_wvalid;
    logic               s_wready;
    logic [W_W-1:0]     s_w;
    logic               s_bvalid;
    logic               s_bready;
    logic [SB_W-1:0]    s_b;
    logic               s_arvalid;
    logic               s_arready;
    logic [SAR_W-1:0]   s_ar;
    logic               s_rvalid;
    logic               s_rready;
    logic [SR_W-1:0]    s_r;

    modport arb (
        input  m_awvalid, m_aw, m_wvalid, m_w, m_bready, m_arvalid, m_ar, m_rready,
        output m_awready, m_wready, m_bvalid, m_b, m_arready, m_rvalid, m_r,
        input  s_awready, s_wready, s_bvalid, s_b, s_arready, s_rvalid, s_r,
        output s_awvalid, s_aw, s_wvalid, s_w, s_bready, s_arvalid, s_ar, s_rready
    );

    modport master (
        output m_awvalid, m_aw, m_wvalid, m_w, m_bready, m_arvalid, m_ar, m_rready,
        input  m_awready, m_wready, m_bvalid, m_b, m_arready, m_rvalid, m_r
    );

    modport slave (
        output s_awready, s_wready, s_bvalid, s_b, s_arready, s_rvalid, s_r,
        input  s_awvalid, s_aw, s_wvalid, s_w, s_bready, s_arvalid, s_ar, s_rready
    );

endinterface

// File: rtl/garnet_ddr_arb_chan.sv
// garnet_ddr_arb_chan
//   One address channel (AW or AR): 2-way round-robin arbiter feeding a single
//   registered output slot, with the winner index prefixed onto the ID.
//   Ports:
//     clk, reset      clock, synchronous active-high reset
//     calib_complete  new grants only while high
//     enable          extra grant qualifier (write-order FIFO not full for AW)
//     req_valid/ready per-master request handshake, ready is a 1-cycle grant pulse
//     req_payload     two packed master payloads, master i at slice i
//     out_valid/ready slave-side handshake of the registered slot
//     out_payload     slot contents with 6-bit ID {winner, id5}
module garnet_ddr_arb_chan
    import garnet_ddr_arb_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                calib_complete,
    input  logic                enable,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*AX_W-1:0]   req_payload,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAX_W-1:0]    out_payload
);

    logic [AX_W-1:0]  req_slice [2];
    logic             slot_valid_reg;
    logic [SAX_W-1:0] slot_payload_reg;
    logic             last_reg;
    logic             slot_free;
    logic             grant;
    logic             winner;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slice
            assign req_slice[gi] = req_payload[gi*AX_W +: AX_W];
        end
    endgenerate

    always_comb begin
        // Slot can accept a new request if empty or being drained this cycle.
        slot_free = !slot_valid_reg || out_ready;
        grant     = !reset && calib_complete && enable && slot_free && (|req_valid);
        // Lone requester wins; on contention the master not granted last wins.
        winner    = (&req_valid) ? ~last_reg : req_valid[1];
        req_ready = 2'b00;
        if (grant) begin
            req_ready = winner ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid_reg   <= 1'b0;
            slot_payload_reg <= '0;
            last_reg         <= 1'b1;
        end else if (grant) begin
            slot_valid_reg   <= 1'b1;
            slot_payload_reg <= prefix_id(req_slice[winner], winner);
            last_reg         <= winner;
        end else if (out_ready) begin
            slot_valid_reg   <= 1'b0;
        end
    end

    assign out_valid   = slot_valid_reg;
    assign out_payload = slot_payload_reg;

endmodule

// File: rtl/garnet_ddr_arb.sv
// garnet_ddr_arb
//   Shares one garnet_ddr AXI4 slave port between two AXI4 masters.
//   AW and AR are arbitrated independently (garnet_ddr_arb_chan each). W beats
//   follow AW grant order through a small order FIFO of master indices.
//   B and R are routed back combinationally by slave ID bit 5.
//   Ports:
//     clk             DDR ui clock
//     reset           synchronous, active-high (shared with the DDR controller)
//     calib_complete  DDR init_calib_complete; low blocks new AW/AR grants only
//     bus             garnet_ddr_arb_if.arb, all master- and slave-side signals
module garnet_ddr_arb
    import garnet_ddr_arb_pkg::*;
#(
    parameter int WQ_DEPTH = 8
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          calib_complete,
    garnet_ddr_arb_if.arb bus
);

    localparam int PTR_W = $clog2(WQ_DEPTH);

    logic             wq_mem_reg [WQ_DEPTH];
    logic [PTR_W-1:0] wq_wr_ptr_reg;
    logic [PTR_W-1:0] wq_rd_ptr_reg;
    logic [PTR_W:0]   wq_count_reg;
    logic             wq_full;
    logic             wq_empty;
    logic             wq_head;
    logic             wq_push;
    logic             wq_push_idx;
    logic             wq_pop;
    logic [W_W-1:0]   m_w_slice [2];
    logic             b_sel;
    logic             r_sel;

    garnet_ddr_arb_chan u_aw_chan (
        .clk            (clk),
        .reset          (reset),
        .calib_complete (calib_complete),
        .enable         (!wq_full),
        .req_valid      (bus.m_awvalid),
        .req_ready      (bus.m_awready),
        .req_payload    (bus.m_aw),
        .out_valid      (bus.s_awvalid),
        .out_ready      (bus.s_awready),
        .out_payload    (bus.s_aw)
    );

    garnet_ddr_arb_chan u_ar_chan (
        .clk            (clk),
        .reset          (reset),
        .calib_complete (calib_complete),
        .enable         (1'b1),
        .req_valid      (bus.m_arvalid),
        .req_ready      (bus.m_arready),
        .req_payload    (bus.m_ar),
        .out_valid      (bus.s_arvalid),
        .out_ready      (bus.s_arready),
        .out_payload    (bus.s_ar)
    );

    // ---------------- write-order FIFO ----------------
    // An AW grant is exactly a pulse on m_awready, whose set bit is the winner.
    assign wq_push     = |bus.m_awready;
    assign wq_push_idx = bus.m_awready[1];
    assign wq_pop      = bus.s_wvalid && bus.s_wready && bus.s_w[W_LAST];
    assign wq_full     = (wq_count_reg == (PTR_W+1)'(WQ_DEPTH));
    assign wq_empty    = (wq_count_reg == '0);
    // The head is read straight from the entry register: the W mux needs it in
    // the same cycle, and a freshly pushed entry only appears after the edge,
    // so a W beat can never ride along with its own AW grant.
    assign wq_head     = wq_mem_reg[wq_rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (wq_push) begin
            wq_mem_reg[wq_wr_ptr_reg] <= wq_push_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wq_wr_ptr_reg <= '0;
            wq_rd_ptr_reg <= '0;
            wq_count_reg  <= '0;
        end else begin
            if (wq_push) begin
                wq_wr_ptr_reg <= wq_wr_ptr_reg + 1'b1;
            end
            if (wq_pop) begin
                wq_rd_ptr_reg <= wq_rd_ptr_reg + 1'b1;
            end
            case ({wq_push, wq_pop})
                2'b10:   wq_count_reg <= wq_count_reg + 1'b1;
                2'b01:   wq_count_reg <= wq_count_reg - 1'b1;
                default: wq_count_reg <= wq_count_reg;
            endcase
        end
    end

    // ---------------- W path ----------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_wslice
            assign m_w_slice[gi] = bus.m_w[gi*W_W +: W_W];
        end
    endgenerate

    assign bus.s_wvalid = !wq_empty && bus.m_wvalid[wq_head];
    assign bus.s_w      = m_w_slice[wq_head];
    assign bus.m_wready = (!wq_empty && bus.s_wready) ? (wq_head ? 2'b10 : 2'b01) : 2'b00;

    // ---------------- B / R routing ----------------
    assign b_sel        = bus.s_b[B_ID_LSB + SID_W - 1];
    assign bus.m_bvalid = bus.s_bvalid ? (b_sel ? 2'b10 : 2'b01) : 2'b00;
    assign bus.s_bready = bus.m_bready[b_sel];
    assign bus.m_b      = bus.s_b[B_W-1:0];

    // Slave R is {data, id6, resp, last}; drop id bit 5 to get the master view.
    assign r_sel        = bus.s_r[R_ID_LSB + SID_W - 1];
    assign bus.m_rvalid = bus.s_rvalid ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
    assign bus.s_rready = bus.m_rready[r_sel];
    assign bus.m_r      = {bus.s_r[SR_W-1:R_ID_LSB+SID_W], bus.s_r[R_ID_LSB+MID_W-1:0]};

endmodule
